// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shift-register link: default word width,
// transmitter FSM states and divider sizing helper.
package shift_reg_pkg;

  localparam int unsigned SR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SH_LO,
    SH_HI,
    LA_LO,
    LA_HI,
    CLR_LO,
    CLR_HI,
    CLR_TL
  } sr_state_t;

  // Divider counter width: enough to hold DIV-1, never less than one bit.
  function automatic int unsigned div_bits(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/shift_reg_driver_if.sv
// Parallel word / clear request handshake into the shift-register driver.
interface shift_reg_driver_if #(
  parameter int unsigned WIDTH = shift_reg_pkg::SR_WIDTH
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             clr_req;

  modport master (
    output tx_data,
    output tx_valid,
    output clr_req,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  clr_req,
    output tx_ready
  );

endinterface

// File: rtl/shift_reg_driver_tick_gen.sv
// Restartable down-counter: tick is high on the count-0 cycle, so with a
// restart on phase entry every phase lasts exactly DIV system clocks.
module sr_tick_gen
  import shift_reg_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned  CW     = div_bits(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count down to zero, reloading on restart or after the tick cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/shift_reg_driver.sv
// Transmit side of the serial-in/parallel-out shift-register link.
// Shifts a WIDTH-bit word out MSB first on sr_data/sr_clk, then pulses
// sr_latch; alternatively runs a clear sequence on sr_reset.
module shift_reg_driver
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = SR_WIDTH,
  parameter int unsigned DIV   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  shift_reg_driver_if.slave        tx,
  output logic                     sr_clk,
  output logic                     sr_data,
  output logic                     sr_latch,
  output logic                     sr_reset,
  output logic                     done
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  sr_state_t        state;
  logic [WIDTH-1:0] buffer;
  logic [WIDTH-1:0] shifted;
  logic [BW-1:0]    bits;
  logic             tick;
  logic             restart;

  // The divider is held at reload while idle; every other transition
  // happens on tick, where the counter reloads by itself, so each state
  // entry starts a full DIV-clock phase.
  assign restart = (state == IDLE);
  assign shifted = buffer << 1;

  sr_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // Transmit FSM with registered link outputs, shift buffer and bit count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      buffer      <= '0;
      bits        <= '0;
      tx.tx_ready <= 1'b0;
      sr_clk      <= 1'b0;
      sr_data     <= 1'b0;
      sr_latch    <= 1'b0;
      sr_reset    <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx.tx_ready <= 1'b1;
          sr_clk      <= 1'b0;
          sr_latch    <= 1'b0;
          sr_reset    <= 1'b0;
          if (tx.tx_ready && tx.clr_req) begin
            tx.tx_ready <= 1'b0;
            sr_reset    <= 1'b1;
            state       <= CLR_LO;
          end else if (tx.tx_ready && tx.tx_valid) begin
            tx.tx_ready <= 1'b0;
            buffer      <= tx.tx_data;
            sr_data     <= tx.tx_data[WIDTH-1];
            bits        <= BW'(WIDTH);
            state       <= SH_LO;
          end
        end
        SH_LO: begin
          if (tick) begin
            sr_clk <= 1'b1;
            state  <= SH_HI;
          end
        end
        SH_HI: begin
          if (tick) begin
            sr_clk <= 1'b0;
            buffer <= shifted;
            bits   <= bits - 1'b1;
            if (bits == BW'(1)) begin
              state <= LA_LO;
            end else begin
              sr_data <= shifted[WIDTH-1];
              state   <= SH_LO;
            end
          end
        end
        LA_LO: begin
          if (tick) begin
            sr_latch <= 1'b1;
            state    <= LA_HI;
          end
        end
        LA_HI: begin
          if (tick) begin
            sr_latch    <= 1'b0;
            done        <= 1'b1;
            tx.tx_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        CLR_LO: begin
          if (tick) begin
            sr_clk <= 1'b1;
            state  <= CLR_HI;
          end
        end
        CLR_HI: begin
          if (tick) begin
            sr_clk <= 1'b0;
            state  <= CLR_TL;
          end
        end
        CLR_TL: begin
          if (tick) begin
            sr_reset    <= 1'b0;
            done        <= 1'b1;
            tx.tx_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
